// File: rtl/m68k_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : m68k_irq_ctrl
//  Purpose  : Parametrised interrupt controller for 68000-based boards.
//             CHANNELS request sources, each with a fixed IPL level and a
//             fixed trigger mode (edge/level). Enables and software clears
//             are applied at runtime. Drives the CPU IPLn lines, answers every
//             interrupt acknowledge with VPAn (autovector), and clears the
//             serviced edge request on the IACK bus cycle.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             src[CHANNELS]       - request inputs (synchronous to clk)
//             enable[CHANNELS]    - per-channel enable
//             sw_clear[CHANNELS]  - one-cycle clear of pending/overrun
//             cpu_fc[3]           - CPU function code
//             cpu_addr[3]         - CPU A3..A1 (acknowledged level in IACK)
//             cpu_as_n, cpu_lds_n - CPU address / lower data strobes
//             ipl_n[3]            - registered active-low priority level
//             vpa_n               - combinational autovector request
//             pending[CHANNELS]   - request state
//             overrun[CHANNELS]   - sticky: edge seen while already pending
//  Revision : 1.0 - initial release
// ============================================================================
module m68k_irq_ctrl #(
    parameter int                    CHANNELS  = 3,
    parameter logic [3*CHANNELS-1:0] LEVEL_MAP = {3'd7, 3'd6, 3'd5},
    parameter logic [CHANNELS-1:0]   EDGE_MASK = 3'b111,
    parameter logic [CHANNELS-1:0]   EDGE_POL  = 3'b000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] src,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] sw_clear,
    input  logic [2:0]          cpu_fc,
    input  logic [2:0]          cpu_addr,
    input  logic                cpu_as_n,
    input  logic                cpu_lds_n,
    output logic [2:0]          ipl_n,
    output logic                vpa_n,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overrun
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] prev_q,    prev_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] overrun_q, overrun_d;
    logic [2:0]          ipl_n_q,   ipl_n_d;
    logic                iack_q,    iack_d;
    // Blocks the acknowledge strobe for an IACK cycle that was already in
    // progress when reset released; cleared once iack is seen low.
    logic                ack_hold_q, ack_hold_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                iack;
    logic                ack_strobe;
    logic [CHANNELS-1:0] edge_hit;
    logic [CHANNELS-1:0] ack_clr;
    logic                ack_found;
    logic [2:0]          max_lvl;

    assign iack       = (&cpu_fc) & ~cpu_as_n & ~cpu_lds_n;
    assign ack_strobe = iack & ~iack_q & ~ack_hold_q;
    assign vpa_n      = ~iack;

    assign ipl_n   = ipl_n_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

    // Edge detection against the previous sample of src.
    always_comb begin
        edge_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (EDGE_POL[i]) begin
                edge_hit[i] = src[i] & ~prev_q[i];
            end else begin
                edge_hit[i] = ~src[i] & prev_q[i];
            end
        end
    end

    // Acknowledge selection: only the lowest-index pending edge channel at
    // the acknowledged level is cleared; same-level peers keep requesting.
    always_comb begin
        ack_clr   = '0;
        ack_found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ack_strobe && !ack_found && EDGE_MASK[i] && pending_q[i] &&
                (LEVEL_MAP[3*i +: 3] == cpu_addr)) begin
                ack_clr[i] = 1'b1;
                ack_found  = 1'b1;
            end
        end
    end

    // Per-channel request / overrun update.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (EDGE_MASK[i]) begin
                if (!enable[i]) begin
                    // Disabled: request dropped, edges discarded, flag kept.
                    pending_d[i] = 1'b0;
                    overrun_d[i] = overrun_q[i] & ~sw_clear[i];
                end else if (edge_hit[i]) begin
                    // A new edge outranks any clear in the same cycle. It
                    // only counts as overrun when no clear coincides.
                    pending_d[i] = 1'b1;
                    if (pending_q[i] && !ack_clr[i] && !sw_clear[i]) begin
                        overrun_d[i] = 1'b1;
                    end else if (sw_clear[i]) begin
                        overrun_d[i] = 1'b0;
                    end
                end else begin
                    if (ack_clr[i] || sw_clear[i]) begin
                        pending_d[i] = 1'b0;
                    end
                    if (sw_clear[i]) begin
                        overrun_d[i] = 1'b0;
                    end
                end
            end else begin
                // Level channel simply follows the gated source.
                pending_d[i] = src[i] & enable[i];
                overrun_d[i] = 1'b0;
            end
        end
    end

    // Highest level among pending channels drives IPLn.
    always_comb begin
        max_lvl = 3'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pending_q[i] && (LEVEL_MAP[3*i +: 3] > max_lvl)) begin
                max_lvl = LEVEL_MAP[3*i +: 3];
            end
        end
        ipl_n_d = ~max_lvl;
    end

    always_comb begin
        prev_d     = src;
        iack_d     = iack;
        ack_hold_d = ack_hold_q & iack;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Loading src avoids a spurious edge straight after reset.
            prev_q     <= src;
            pending_q  <= '0;
            overrun_q  <= '0;
            ipl_n_q    <= 3'b111;
            iack_q     <= 1'b0;
            ack_hold_q <= 1'b1;
        end else begin
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            ipl_n_q    <= ipl_n_d;
            iack_q     <= iack_d;
            ack_hold_q <= ack_hold_d;
        end
    end

endmodule
`default_nettype wire
